aes_key_expand_seq: RTL and testbench

// - Iterative AES-128 key schedule; sits directly upstream of the combinational encrypt core and drives its expanded-key bus.
// - Accepts a 128-bit cipher key on a start pulse, generates words w[4..43] at one word per clock, then presents all 44 words.
// - Asserts valid until the next start. Replaces a fully combinational schedule and cuts the S-box depth to one SubWord per cycle.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_expand_seq.sv | 93 +++++++++
 tb/tb_aes_key_expand_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type, S-box table and Rcon lookup for the key schedule.
package aes_pkg;

   localparam int NR     = 10;
   localparam int NK     = 4;
   localparam int NWORDS = NK * (NR + 1);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Round constant for round index i (0..9); anything else returns 0 so idle-state
   // index arithmetic never produces X.
   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: the AES S-box applied independently to each of the four bytes.
module aes_sub_word (
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);
   import aes_pkg::*;

   // One S-box lookup per byte lane
   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
   end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one expanded word per clock, all 44 words presented
// on w once valid rises. w is a live view of the word registers and is only meaningful
// while valid is high.
module aes_key_expand_seq #(
   parameter int NR = aes_pkg::NR
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [127:0]                    key,
   output logic                            busy,
   output logic                            valid,
   output logic [32*aes_pkg::NWORDS-1:0]   w
);
   import aes_pkg::*;

   if (NR != 10) begin : g_bad_nr
      $error("aes_key_expand_seq: only NR=10 (AES-128) is supported");
   end

   localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);

   // Word 0 is the leftmost element, so the packed array maps straight onto w.
   logic [0:NWORDS-1][31:0] r_word;
   logic [5:0]              r_idx;
   state_t                  r_state;
   state_t                  w_next;

   logic        w_accept;
   logic        w_last;
   logic [31:0] w_prev;
   logic [31:0] w_rot;
   logic [31:0] w_sub;
   logic [31:0] w_t;
   logic [7:0]  w_rcon;

   assign w_accept = start && (r_state != EXPAND);
   assign w_last   = (r_idx == LAST_IDX);

   // Datapath: t = word[idx-1], with RotWord/SubWord/Rcon on every fourth word
   assign w_prev = r_word[r_idx - 6'd1];
   assign w_rot  = {w_prev[23:0], w_prev[31:24]};
   assign w_rcon = rcon(r_idx[5:2] - 4'd1);
   assign w_t    = (r_idx[1:0] == 2'b00) ? (w_sub ^ {w_rcon, 24'h0}) : w_prev;

   aes_sub_word u_sub_word (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; start is only honoured outside EXPAND
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start)  w_next = EXPAND;
         EXPAND:  if (w_last) w_next = DONE;
         DONE:    if (start)  w_next = EXPAND;
         default: w_next = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy  = (r_state == EXPAND);
      valid = (r_state == DONE);
   end

   // Word register file and index: load key on accept, then one word per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_idx  <= '0;
      end else if (w_accept) begin
         r_word[0] <= key[127:96];
         r_word[1] <= key[95:64];
         r_word[2] <= key[63:32];
         r_word[3] <= key[31:0];
         r_idx     <= 6'd4;
      end else if (r_state == EXPAND) begin
         r_word[r_idx] <= r_word[r_idx - 6'd4] ^ w_t;
         if (!w_last) r_idx <= r_idx + 6'd1;
      end
   end

   assign w = r_word;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for the iterative AES-128 key schedule using FIPS-197 vectors.
module tb_aes_key_expand_seq;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [127:0]  key = '0;
   logic          busy;
   logic          valid;
   logic [1407:0] w;

   aes_key_expand_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .key   (key),
      .busy  (busy),
      .valid (valid),
      .w     (w)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] key;
      logic [127:0] rk1;
      logic [127:0] rk10;
   } vec_t;

   vec_t vecs [3];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   aborted;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic logic [127:0] rk(input int r);
      return w[1407-128*r -: 128];
   endfunction

   // Start an expansion with k; optionally pulse start with a different key at
   // cycles 5 and 20, or assert reset after rst_at cycles.
   task automatic run(input string nm, input logic [127:0] k, input bit glitch,
                      input int rst_at, output bit ab);
      int n;
      int busy_lo;
      ab = 1'b0;
      @(negedge clk);
      key   = k;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      key   = ~k;
      chk({nm, "_acc_busy"}, 128'(busy), 128'd1);
      chk({nm, "_acc_valid"}, 128'(valid), 128'd0);
      chk({nm, "_acc_rk0"}, rk(0), k);
      n = 0;
      busy_lo = 0;
      while (!valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (!valid && !busy) busy_lo++;
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk({nm, "_rst_busy"}, 128'(busy), 128'd0);
            chk({nm, "_rst_valid"}, 128'(valid), 128'd0);
            chk({nm, "_rst_w_nonzero"}, 128'(|w), 128'd0);
            @(negedge clk);
            rst_n = 1'b1;
            ab = 1'b1;
            return;
         end
         start = glitch && (n == 5 || n == 20);
         if (start) key = k ^ 128'h5555_aaaa_0f0f_f0f0_3333_cccc_1234_5678;
      end
      start = 1'b0;
      chk({nm, "_latency"}, 128'(n), 128'd40);
      chk({nm, "_busy_gaps"}, 128'(busy_lo), 128'd0);
      chk({nm, "_done_busy"}, 128'(busy), 128'd0);
   endtask

   initial begin
      vecs[0] = '{"a1",   128'h2b7e151628aed2a6abf7158809cf4f3c,
                          128'ha0fafe1788542cb123a339392a6c7605,
                          128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{"c1",   128'h000102030405060708090a0b0c0d0e0f,
                          128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                          128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[2] = '{"zero", 128'h0,
                          128'h62636363626363636263636362636363,
                          128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      // Reset state
      #12;
      chk("reset_busy", 128'(busy), 128'd0);
      chk("reset_valid", 128'(valid), 128'd0);
      chk("reset_w_nonzero", 128'(|w), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven schedules; the 2nd and 3rd runs restart from DONE
      for (int i = 0; i < 3; i++) begin
         run(vecs[i].name, vecs[i].key, 1'b0, -1, aborted);
         chk({vecs[i].name, "_rk0"}, rk(0), vecs[i].key);
         chk({vecs[i].name, "_rk1"}, rk(1), vecs[i].rk1);
         chk({vecs[i].name, "_rk10"}, rk(10), vecs[i].rk10);
      end

      // DONE holds valid and w
      repeat (7) @(negedge clk);
      chk("hold_valid", 128'(valid), 128'd1);
      chk("hold_rk10", rk(10), vecs[2].rk10);
      chk("hold_w4", 128'(w[1407-32*4 -: 32]), 128'h62636363);

      // start pulses during expansion are ignored
      run("glitch", vecs[0].key, 1'b1, -1, aborted);
      chk("glitch_rk1", rk(1), vecs[0].rk1);
      chk("glitch_rk10", rk(10), vecs[0].rk10);
      chk("glitch_w43", 128'(w[31:0]), 128'hb6630ca6);

      // Reset at idx=17 aborts, then a fresh start completes correctly
      run("abort", vecs[1].key, 1'b0, 13, aborted);
      chk("abort_taken", 128'(aborted), 128'd1);
      run("after_rst", vecs[1].key, 1'b0, -1, aborted);
      chk("after_rst_rk1", rk(1), vecs[1].rk1);
      chk("after_rst_rk10", rk(10), vecs[1].rk10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
